// File: rtl/button_conditioner.sv
// Button front end: 2-flop synchronizer, debounce FSM, press/release strobes, sticky press request.
// Define BUTTON_CONDITIONER_LONG_PRESS_EN to build the long-press hold timer; `release` is a keyword, so that strobe is release_strobe.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned LONG_CYCLES     = 27000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       shift_ack,
  output logic       level_n,
  output logic       press,
  output logic       release_strobe,
  output logic       pending,
  output logic [7:0] press_count,
  output logic       long_press
);

  typedef enum logic [1:0] {
    UP     = 2'd0,
    CHK_DN = 2'd1,
    DOWN   = 2'd2,
    CHK_UP = 2'd3
  } state_t;

  localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 2);

  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        level_n_q, level_n_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        pending_q, pending_d;
  logic [7:0]  count_q, count_d;

  always_comb begin
    s1_d = btn_n;
    s2_d = s1_q;
  end

  // Synchronizer idles released so a reset never looks like a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_n_d = level_n_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      UP: begin
        if (!s2_q) begin
          state_d = CHK_DN;
          cnt_d   = '0;
        end
      end
      CHK_DN: begin
        if (s2_q) begin
          state_d = UP;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DOWN;
          level_n_d = 1'b0;
          press_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      DOWN: begin
        if (s2_q) begin
          state_d = CHK_UP;
          cnt_d   = '0;
        end
      end
      CHK_UP: begin
        if (!s2_q) begin
          state_d = DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = UP;
          level_n_d = 1'b1;
          release_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: begin
        state_d = UP;
      end
    endcase
  end

  // A press arriving with an acknowledge wins so no request is ever lost.
  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    if (press_d) begin
      pending_d = 1'b1;
      count_d   = count_q + 8'd1;
    end else if (shift_ack) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= UP;
      cnt_q     <= '0;
      level_n_q <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      pending_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_n_q <= level_n_d;
      press_q   <= press_d;
      release_q <= release_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign level_n        = level_n_q;
  assign press          = press_q;
  assign release_strobe = release_q;
  assign pending        = pending_q;
  assign press_count    = count_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam logic [24:0] HOLD_MAX  = 25'(LONG_CYCLES);
  localparam logic [24:0] HOLD_LAST = 25'(LONG_CYCLES - 1);

  logic [24:0] hold_q, hold_d;
  logic        long_q, long_d;

  // Hold time keeps accruing through CHK_UP; only a committed release ends the long press.
  always_comb begin
    hold_d = hold_q;
    long_d = long_q;
    if (state_d == DOWN && state_q != DOWN) begin
      hold_d = '0;
    end else if ((state_q == DOWN || state_q == CHK_UP) && hold_q < HOLD_MAX) begin
      hold_d = hold_q + 25'd1;
    end
    if (release_d) begin
      long_d = 1'b0;
    end else if ((state_d == DOWN || state_d == CHK_UP) && hold_d >= HOLD_LAST) begin
      long_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Expected strobes are queued when the pin is driven and matched by a negedge monitor.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_n;
  logic       shift_ack;
  logic       level_n;
  logic       press;
  logic       release_strobe;
  logic       pending;
  logic [7:0] press_count;
  logic       long_press;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_n         (btn_n),
    .shift_ack     (shift_ack),
    .level_n       (level_n),
    .press         (press),
    .release_strobe(release_strobe),
    .pending       (pending),
    .press_count   (press_count),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_press;
    int         at;
    logic [7:0] count;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] exp_count;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive changes land just after edge cyc, so the pin is sampled at cyc+1 and commits at cyc+6.
  task automatic expect_press(input int at);
    exp_count++;
    exp_q.push_back('{1'b1, at, exp_count});
  endtask

  task automatic expect_release(input int at);
    exp_q.push_back('{1'b0, at, exp_count});
  endtask

  task automatic clean_press(input int hold, input int gap);
    btn_n = 1'b0;
    expect_press(cyc + 6);
    tick(hold);
    btn_n = 1'b1;
    expect_release(cyc + 6);
    tick(gap);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      check("strobe_missing", cyc, exp_q[0].at);
      void'(exp_q.pop_front());
    end
    if (press || release_strobe) begin
      check("strobe_exclusive", {31'd0, press & release_strobe}, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, press, release_strobe}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind", {31'd0, press}, {31'd0, mon_e.is_press});
        check("strobe_cycle", cyc, mon_e.at);
        if (press) begin
          check("count_on_press", press_count, mon_e.count);
          check("pending_on_press", pending, 1);
          check("level_on_press", level_n, 0);
        end else begin
          check("level_on_release", level_n, 1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset     = 1'b0;
    btn_n     = 1'b1;
    shift_ack = 1'b0;
    exp_count = 8'd0;

    // Reset held with a toggling pin: outputs must sit at reset values.
    for (int i = 0; i < 6; i++) begin
      btn_n = i[0];
      tick(1);
      check("rst_level_n", level_n, 1);
      check("rst_strobes", {30'd0, press, release_strobe}, 0);
      check("rst_pending", pending, 0);
      check("rst_count", press_count, 0);
      check("rst_long", long_press, 0);
    end
    btn_n = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(10);
    check("post_rst_level_n", level_n, 1);

    // Clean press and release.
    clean_press(10, 10);
    check("clean_count", press_count, exp_count);
    check("clean_pending", pending, 1);
    check("clean_level_n", level_n, 1);

    // Acknowledge clears pending; a stray acknowledge is ignored.
    shift_ack = 1'b1;
    tick(1);
    shift_ack = 1'b0;
    check("ack_clears", pending, 0);
    shift_ack = 1'b1;
    tick(1);
    shift_ack = 1'b0;
    check("stray_ack_pending", pending, 0);
    check("stray_ack_count", press_count, 1);

    // Acknowledge on the same edge as a new press: press wins.
    btn_n = 1'b0;
    expect_press(cyc + 6);
    tick(5);
    shift_ack = 1'b1;
    tick(1);
    shift_ack = 1'b0;
    check("coincident_pending", pending, 1);
    check("coincident_count", press_count, 2);
    tick(5);
    btn_n = 1'b1;
    expect_release(cyc + 6);
    tick(10);
    shift_ack = 1'b1;
    tick(1);
    shift_ack = 1'b0;
    check("ack_clears_2", pending, 0);

    // Bounce: 3 low, 2 high, then steady low; one press after the final fall.
    btn_n = 1'b0;
    tick(3);
    btn_n = 1'b1;
    tick(2);
    btn_n = 1'b0;
    expect_press(cyc + 6);
    tick(10);
    check("bounce_count", press_count, 3);
    btn_n = 1'b1;
    expect_release(cyc + 6);
    tick(10);

    // Long hold of 30 cycles.
    begin
      int c;
      logic exp_long;
      c = cyc;
      btn_n = 1'b0;
      expect_press(c + 6);
      for (int i = 1; i <= 40; i++) begin
        tick(1);
        if (i == 30) begin
          btn_n = 1'b1;
          expect_release(c + 36);
        end
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
        exp_long = (i >= 25) && (i < 36);
`else
        exp_long = 1'b0;
`endif
        check("long_press", long_press, {31'd0, exp_long});
      end
    end
    tick(5);

    // Reset mid-CHK_DN: no press, back to UP.
    btn_n = 1'b0;
    tick(3);
    reset = 1'b0;
    #1;
    check("midchk_level_n", level_n, 1);
    check("midchk_press", press, 0);
    check("midchk_count", press_count, 0);
    check("midchk_pending", pending, 0);
    exp_count = 8'd0;
    btn_n = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(10);
    check("after_midchk_level_n", level_n, 1);

    // Full-latency press from UP, then 255 more to wrap the counter.
    clean_press(10, 10);
    check("first_after_reset", press_count, 1);
    for (int i = 0; i < 255; i++) begin
      clean_press(8, 8);
    end
    check("wrap_count", press_count, 0);

    tick(10);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
